// File: rtl/fifo_status_monitor_pkg.sv
// Shared constants for the FIFO status monitor: FIFO indices, threshold
// word layout and FSM state encoding.
package fifo_status_monitor_pkg;

   localparam int NUM_FIFO = 5;

   localparam int IDX_MF  = 0;
   localparam int IDX_VC0 = 1;
   localparam int IDX_D0  = 2;
   localparam int IDX_VC1 = 3;
   localparam int IDX_D1  = 4;

   localparam int UMB_W   = 14;

   // umbrales_I = {MF[13:12], VC0[11:8], D0[7:6], VC1[5:2], D1[1:0]}
   localparam int OFF_MF  = 12;
   localparam int W_MF    = 2;
   localparam int OFF_VC0 = 8;
   localparam int W_VC0   = 4;
   localparam int OFF_D0  = 6;
   localparam int W_D0    = 2;
   localparam int OFF_VC1 = 2;
   localparam int W_VC1   = 4;
   localparam int OFF_D1  = 0;
   localparam int W_D1    = 2;

   typedef enum logic {
      UNCFG  = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   // Bit offset of a FIFO's threshold field inside umbrales_I
   function automatic int th_off(input int idx);
      case (idx)
         IDX_MF:  th_off = OFF_MF;
         IDX_VC0: th_off = OFF_VC0;
         IDX_D0:  th_off = OFF_D0;
         IDX_VC1: th_off = OFF_VC1;
         default: th_off = OFF_D1;
      endcase
   endfunction

   // Width of a FIFO's threshold field; the wide ones belong to the deep FIFOs
   function automatic int th_w(input int idx);
      case (idx)
         IDX_VC0: th_w = W_VC0;
         IDX_VC1: th_w = W_VC1;
         default: th_w = W_MF;
      endcase
   endfunction

endpackage

// File: rtl/fifo_status_monitor_counter.sv
// One FIFO's occupancy tracker: saturating counter, sticky over/underflow
// flag and almost-full threshold compare. All outputs are registered from
// the post-update count so they follow a strobe by one cycle.
module fifo_occupancy_counter #(
   parameter int DEPTH = 4,
   parameter int TH_W  = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic            pop,
   input  logic            err_clear,
   input  logic            active,
   input  logic [TH_W-1:0] th,
   output logic            empty,
   output logic            error,
   output logic            almost_full,
   output logic            af_nxt
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic [CW-1:0] th_ext;
   logic          ev;

   assign th_ext = {{(CW-TH_W){1'b0}}, th};

   // Next count and error event; illegal strobes hold the count, except a
   // push&pop on empty where the push still lands.
   always_comb begin
      cnt_d = cnt_q;
      ev    = 1'b0;
      case ({push, pop})
         2'b10: begin
            if (cnt_q == CW'(DEPTH)) ev = 1'b1;
            else                     cnt_d = cnt_q + CW'(1);
         end
         2'b01: begin
            if (cnt_q == '0) ev = 1'b1;
            else             cnt_d = cnt_q - CW'(1);
         end
         2'b11: begin
            if (cnt_q == '0) begin
               ev    = 1'b1;
               cnt_d = CW'(1);
            end
         end
         default: ;
      endcase
      af_nxt = active && (th != '0) && (cnt_d >= th_ext);
   end

   // Register count and status; a new error event beats a simultaneous clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q       <= '0;
         empty       <= 1'b1;
         error       <= 1'b0;
         almost_full <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         empty       <= (cnt_d == '0);
         error       <= (error & ~err_clear) | ev;
         almost_full <= af_nxt;
      end
   end

endmodule

// File: rtl/fifo_status_monitor.sv
// Flow-control responder: holds the threshold register and config FSM,
// fans the packed threshold word out to five per-FIFO trackers and
// produces the global pause.
module fifo_status_monitor
   import fifo_status_monitor_pkg::*;
#(
   parameter int DEPTH_S = 4,
   parameter int DEPTH_L = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_umbrales,
   input  logic [13:0] umbrales_I,
   input  logic [4:0]  push,
   input  logic [4:0]  pop,
   input  logic        err_clear,
   output logic [4:0]  FIFO_empty,
   output logic [4:0]  FIFO_error,
   output logic [4:0]  almost_full,
   output logic        pause,
   output logic        configured
);

   state_t             state_q;
   logic [UMB_W-1:0]   th_q;
   logic [NUM_FIFO-1:0] af_nxt;
   logic               active;

   assign active = (state_q == ACTIVE);

   // Config FSM, threshold capture and registered pause
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= UNCFG;
         th_q       <= '0;
         configured <= 1'b0;
         pause      <= 1'b0;
      end else begin
         pause <= |af_nxt;
         case (state_q)
            UNCFG: begin
               if (load_umbrales) begin
                  state_q    <= ACTIVE;
                  th_q       <= umbrales_I;
                  configured <= 1'b1;
               end
            end
            ACTIVE: begin
               if (load_umbrales) th_q <= umbrales_I;
            end
         endcase
      end
   end

   for (genvar i = 0; i < NUM_FIFO; i++) begin : g_fifo
      if (th_w(i) == W_VC0) begin : g_l
         fifo_occupancy_counter #(.DEPTH(DEPTH_L), .TH_W(W_VC0)) u_cnt (
            .clk         (clk),
            .reset       (reset),
            .push        (push[i]),
            .pop         (pop[i]),
            .err_clear   (err_clear),
            .active      (active),
            .th          (th_q[th_off(i) +: W_VC0]),
            .empty       (FIFO_empty[i]),
            .error       (FIFO_error[i]),
            .almost_full (almost_full[i]),
            .af_nxt      (af_nxt[i])
         );
      end else begin : g_s
         fifo_occupancy_counter #(.DEPTH(DEPTH_S), .TH_W(W_MF)) u_cnt (
            .clk         (clk),
            .reset       (reset),
            .push        (push[i]),
            .pop         (pop[i]),
            .err_clear   (err_clear),
            .active      (active),
            .th          (th_q[th_off(i) +: W_MF]),
            .empty       (FIFO_empty[i]),
            .error       (FIFO_error[i]),
            .almost_full (almost_full[i]),
            .af_nxt      (af_nxt[i])
         );
      end
   end

endmodule

// File: tb/tb_fifo_status_monitor.sv
// Scoreboard bench for fifo_status_monitor: each cycle the reference model
// pushes the expected output vector, the test task pops and compares it
// after the edge, alongside directed checks of key scenario points.
module tb_fifo_status_monitor;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_umbrales;
   logic [13:0] umbrales_I;
   logic [4:0]  push, pop;
   logic        err_clear;
   logic [4:0]  FIFO_empty, FIFO_error, almost_full;
   logic        pause, configured;

   fifo_status_monitor #(.DEPTH_S(4), .DEPTH_L(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .load_umbrales (load_umbrales),
      .umbrales_I    (umbrales_I),
      .push          (push),
      .pop           (pop),
      .err_clear     (err_clear),
      .FIFO_empty    (FIFO_empty),
      .FIFO_error    (FIFO_error),
      .almost_full   (almost_full),
      .pause         (pause),
      .configured    (configured)
   );

   always #5 clk = ~clk;

   // {empty, error, almost_full, pause, configured}
   localparam logic [16:0] RST_VEC = {5'b11111, 5'b0, 5'b0, 1'b0, 1'b0};
   localparam logic [13:0] UMB_A   = {2'd3, 4'd8, 2'd2, 4'd12, 2'd1};

   int          n_vec = 0;
   int          n_bad = 0;
   logic [16:0] exp_q[$];

   int          m_cnt[5];
   int          m_th[5];
   logic [4:0]  m_err;
   bit          m_act;

   function automatic logic [16:0] obs();
      return {FIFO_empty, FIFO_error, almost_full, pause, configured};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 5; i++) begin
         m_cnt[i] = 0;
         m_th[i]  = 0;
      end
      m_err = '0;
      m_act = 1'b0;
      exp_q.delete();
   endtask

   // Drive one cycle of stimulus and queue the model's expected outputs
   task automatic cyc(input logic [4:0] p, input logic [4:0] q, input logic ld,
                      input logic [13:0] u, input logic clr);
      logic [4:0] emp, af;
      int dep, c;
      bit ev;
      for (int i = 0; i < 5; i++) begin
         dep = (i == 1 || i == 3) ? 16 : 4;
         c   = m_cnt[i];
         ev  = 1'b0;
         if (p[i] && !q[i]) begin
            if (c == dep) ev = 1'b1; else c = c + 1;
         end else if (!p[i] && q[i]) begin
            if (c == 0) ev = 1'b1; else c = c - 1;
         end else if (p[i] && q[i] && c == 0) begin
            ev = 1'b1;
            c  = 1;
         end
         m_cnt[i] = c;
         m_err[i] = (m_err[i] && !clr) || ev;
         af[i]    = m_act && (m_th[i] != 0) && (c >= m_th[i]);
         emp[i]   = (c == 0);
      end
      exp_q.push_back({emp, m_err, af, |af, m_act || ld});
      if (ld) begin
         m_act   = 1'b1;
         m_th[0] = int'(u[13:12]);
         m_th[1] = int'(u[11:8]);
         m_th[2] = int'(u[7:6]);
         m_th[3] = int'(u[5:2]);
         m_th[4] = int'(u[1:0]);
      end
      push          = p;
      pop           = q;
      load_umbrales = ld;
      umbrales_I    = u;
      err_clear     = clr;
      @(posedge clk);
      #1;
      push          = '0;
      pop           = '0;
      load_umbrales = 1'b0;
      err_clear     = 1'b0;
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      push          = '0;
      pop           = '0;
      load_umbrales = 1'b0;
      umbrales_I    = '0;
      err_clear     = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [16:0] got, ex;
      do_reset();
      n_vec++;
      if (obs() !== RST_VEC) begin
         n_bad++;
         $display("FAIL reset_initial: got %b want %b", obs(), RST_VEC);
      end
      cyc(5'b0, 5'b0, 1'b1, UMB_A, 1'b0);
      for (int k = 0; k < 8; k++) begin
         if (k > 0) cyc(5'b00010, 5'b0, 1'b0, '0, 1'b0);
         got = obs();
         ex  = exp_q.pop_front();
         n_vec++;
         if (got !== ex) begin
            n_bad++;
            $display("FAIL reset_prefill step %0d: got %b want %b", k, got, ex);
         end
      end
      // VC0 now holds 7; assert reset away from any clock edge
      #2;
      reset = 1'b1;
      #1;
      n_vec++;
      if (obs() !== RST_VEC) begin
         n_bad++;
         $display("FAIL reset_async: got %b want %b", obs(), RST_VEC);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (obs() !== RST_VEC) begin
         n_bad++;
         $display("FAIL reset_held: got %b want %b", obs(), RST_VEC);
      end
      model_clear();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      // one empty-FIFO push after release proves count restarted from 0
      cyc(5'b00010, 5'b0, 1'b0, '0, 1'b0);
      got = obs();
      ex  = exp_q.pop_front();
      n_vec++;
      if (got !== ex || FIFO_error !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_restart: got %b want %b", got, ex);
      end
   endtask

   task automatic test_threshold();
      logic [16:0] got, ex;
      do_reset();
      for (int k = 0; k <= 8; k++) begin
         if (k == 0) cyc(5'b0, 5'b0, 1'b1, UMB_A, 1'b0);
         else        cyc(5'b00010, 5'b0, 1'b0, '0, 1'b0);
         got = obs();
         ex  = exp_q.pop_front();
         n_vec++;
         if (got !== ex) begin
            n_bad++;
            $display("FAIL threshold step %0d: got %b want %b", k, got, ex);
         end
         if (k == 7) begin
            n_vec++;
            if (almost_full[1] !== 1'b0 || pause !== 1'b0) begin
               n_bad++;
               $display("FAIL threshold_below: af=%b pause=%b want af[1]=0 pause=0", almost_full, pause);
            end
         end
      end
      n_vec++;
      if (almost_full[1] !== 1'b1 || pause !== 1'b1 || configured !== 1'b1) begin
         n_bad++;
         $display("FAIL threshold_hit: af=%b pause=%b cfg=%b want af[1]=1 pause=1 cfg=1",
                  almost_full, pause, configured);
      end
   endtask

   task automatic test_overflow();
      logic [16:0] got, ex;
      do_reset();
      cyc(5'b0, 5'b0, 1'b1, UMB_A, 1'b0);
      void'(exp_q.pop_front());
      for (int k = 1; k <= 11; k++) begin
         if (k <= 5)       cyc(5'b00001, 5'b0, 1'b0, '0, 1'b0);
         else if (k <= 9)  cyc(5'b0, 5'b00001, 1'b0, '0, 1'b0);
         else if (k == 10) cyc(5'b0, 5'b0, 1'b0, '0, 1'b0);
         else              cyc(5'b0, 5'b0, 1'b0, '0, 1'b1);
         got = obs();
         ex  = exp_q.pop_front();
         n_vec++;
         if (got !== ex) begin
            n_bad++;
            $display("FAIL overflow step %0d: got %b want %b", k, got, ex);
         end
         if (k == 4 || k == 5 || k == 10 || k == 11) begin
            n_vec++;
            if (FIFO_error[0] !== (k == 5 || k == 10)) begin
               n_bad++;
               $display("FAIL overflow_err step %0d: error=%b", k, FIFO_error);
            end
         end
         if (k == 8 || k == 9) begin
            n_vec++;
            if (FIFO_empty[0] !== (k == 9)) begin
               n_bad++;
               $display("FAIL overflow_held step %0d: empty=%b", k, FIFO_empty);
            end
         end
      end
   endtask

   task automatic test_underflow();
      logic [16:0] got, ex;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         case (k)
            0: cyc(5'b00000, 5'b10000, 1'b0, '0, 1'b0);
            1: cyc(5'b00100, 5'b00100, 1'b0, '0, 1'b0);
            2: cyc(5'b00000, 5'b00100, 1'b0, '0, 1'b0);
            default: cyc(5'b0, 5'b0, 1'b0, '0, 1'b1);
         endcase
         got = obs();
         ex  = exp_q.pop_front();
         n_vec++;
         if (got !== ex) begin
            n_bad++;
            $display("FAIL underflow step %0d: got %b want %b", k, got, ex);
         end
         if (k == 0) begin
            n_vec++;
            if (FIFO_error[4] !== 1'b1 || FIFO_empty[4] !== 1'b1) begin
               n_bad++;
               $display("FAIL underflow_d1: error=%b empty=%b", FIFO_error, FIFO_empty);
            end
         end
         if (k == 1) begin
            n_vec++;
            if (FIFO_error[2] !== 1'b1 || FIFO_empty[2] !== 1'b0) begin
               n_bad++;
               $display("FAIL pushpop_empty_d0: error=%b empty=%b", FIFO_error, FIFO_empty);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [16:0] got, ex;
      do_reset();
      cyc(5'b0, 5'b0, 1'b1, UMB_A, 1'b0);
      void'(exp_q.pop_front());
      for (int k = 1; k <= 19; k++) begin
         if (k <= 16)      cyc(5'b01000, 5'b0, 1'b0, '0, 1'b0);
         else if (k == 17) cyc(5'b01000, 5'b01000, 1'b0, '0, 1'b0);
         else if (k == 18) cyc(5'b01000, 5'b0, 1'b0, '0, 1'b1);
         else              cyc(5'b0, 5'b0, 1'b0, '0, 1'b1);
         got = obs();
         ex  = exp_q.pop_front();
         n_vec++;
         if (got !== ex) begin
            n_bad++;
            $display("FAIL back_to_back step %0d: got %b want %b", k, got, ex);
         end
         if (k >= 17) begin
            n_vec++;
            if (FIFO_error[3] !== (k == 18)) begin
               n_bad++;
               $display("FAIL vc1_err step %0d: error=%b", k, FIFO_error);
            end
         end
      end
   endtask

   task automatic test_unconfigured();
      logic [16:0] got, ex;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         if (k < 4)       cyc(5'b00011, 5'b0, 1'b0, '0, 1'b0);
         else if (k == 4) cyc(5'b0, 5'b0, 1'b1, 14'd0, 1'b0);
         else             cyc(5'b11111, 5'b0, 1'b0, '0, 1'b0);
         got = obs();
         ex  = exp_q.pop_front();
         n_vec++;
         if (got !== ex) begin
            n_bad++;
            $display("FAIL unconfigured step %0d: got %b want %b", k, got, ex);
         end
         n_vec++;
         if (almost_full !== 5'b0 || pause !== 1'b0) begin
            n_bad++;
            $display("FAIL unconfigured_af step %0d: af=%b pause=%b want 0", k, almost_full, pause);
         end
      end
   endtask

   task automatic test_random();
      logic [16:0] got, ex;
      do_reset();
      cyc(5'b0, 5'b0, 1'b1, 14'($urandom), 1'b0);
      void'(exp_q.pop_front());
      for (int k = 0; k < 400; k++) begin
         cyc(5'($urandom), 5'($urandom), ($urandom_range(0, 15) == 0),
             14'($urandom), ($urandom_range(0, 7) == 0));
         got = obs();
         ex  = exp_q.pop_front();
         n_vec++;
         if (got !== ex) begin
            n_bad++;
            $display("FAIL random step %0d: got %b want %b", k, got, ex);
         end
      end
   endtask

   initial begin
      test_reset();
      test_threshold();
      test_overflow();
      test_underflow();
      test_back_to_back();
      test_unconfigured();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
